dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every load/store of the RV32I core onto a word-wide, handshaked data-memory bus.
- Takes DMWr and DMCtrl from the control unit, plus the address and store data from the datapath.
- Stalls the core until the access completes.
- Aligns and extends load data.
- Generates byte enables for stores.
- Splits misaligned halfword/word accesses into two word transactions.

Parameters:
- ALLOW_MISALIGN, 1: 1 = split boundary-crossing accesses into two transactions; 0 = flag them as Err with no bus traffic.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Req  in  1  core requests a memory access; held stable with all request fields while Stall=1.
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- Addr  in  32  byte address.
- WrData  in  32  store data; low byte/half/word used.
- Stall  out  1  freeze the core PC/pipeline.
- Done  out  1  one-cycle pulse; the access is complete.
- RdData  out  32  extended load result; valid while Done=1.
- Err  out  1  with Done: illegal DMCtrl, or misaligned access when ALLOW_MISALIGN=0.
- BusReq  out  1  bus transaction valid.
- BusWe  out  1  transaction is a write.
- BusAddr  out  32  word address; bits [1:0] are always 00.
- BusBe  out  4  byte enables; write only, 0000 on reads.
- BusWData  out  32  lane-aligned write data.
- BusGnt  in  1  bus accepts the transaction this cycle (accepted when BusReq & BusGnt).
- BusRData  in  32  read word.
- BusRValid  in  1  read data valid; at least 1 cycle after acceptance.

Behaviour:
- Reset (async, immediate): state IDLE; Stall, Done, Err, BusReq, BusWe, BusBe all 0; RdData 0; internal data/lo-word regs 0.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE:
  - on Req, register Addr/DMWr/DMCtrl/WrData.
  - Compute size (1/2/4) and split = (Addr[1:0] + size > 4).
  - Illegal code (011, 110, 111; or 1xx with DMWr=1) or (split and ALLOW_MISALIGN=0) → DONE with Err=1.
  - Otherwise → ISSUE0.
- ISSUE0:
  - drive BusReq=1, BusAddr = {Addr[31:2],00}, BusWe = DMWr.
  - Store lanes: {BusBe1, BusBe0} = mask(size) << Addr[1:0]; {BusWData1, BusWData0} = WrData << 8*Addr[1:0] (64-bit shift).
  - BusReq and all bus fields are held until BusGnt.
  - On accept: write → ISSUE1 if split, else DONE; read → WAIT0.
- WAIT0: on BusRValid, capture lo word; → ISSUE1 if split, else DONE.
- ISSUE1:
  - BusAddr = {Addr[31:2],00} + 4, wrapping 0xFFFFFFFC → 0x00000000.
  - Lanes are the high halves of the 64-bit shifts.
  - On accept: write → DONE; read → WAIT1.
- WAIT1: on BusRValid, capture hi word → DONE.
- DONE:
  - Done=1, Stall=0; RdData = extend(({hi,lo} >> 8*Addr[1:0]) sized), sign-extend for B/H, zero-extend for BU/HU. hi=0 when not split.
  - Always → IDLE.
- Stall = Req & (state != DONE), combinational. The core sees Stall=0 exactly in the Done cycle.
- A new Req in the cycle after DONE starts a fresh access; no back-to-back bypass.
- Req dropping mid-access is illegal; the block completes the access anyway.
- BusRValid in a non-WAIT state is ignored. BusGnt in a non-ISSUE state is ignored.
- Minimum latency, aligned store with immediate grant: Stall high 2 cycles (IDLE, ISSUE0), Done in cycle 3.
- Aligned load with RValid 1 cycle after grant: Done in cycle 4.
- Reset mid-transaction: BusReq drops asynchronously; any outstanding read data is discarded.

Test Plan:
- SW Addr=0x100, WrData=0xDEADBEEF, BusGnt=1 → one transaction, BusAddr=0x100, BusBe=1111, BusWData=0xDEADBEEF; Done on 3rd cycle, Err=0.
- LB Addr=0x203, BusRData=0x80112233 → BusBe=0000, RdData=0xFFFFFF80; LBU same stimulus → RdData=0x00000080.
- SH Addr=0x103, WrData=0x0000A1B2, ALLOW_MISALIGN=1 → txn 1: Addr 0x100, Be=1000, WData[31:24]=B2; txn 2: Addr 0x104, Be=0001, WData[7:0]=A1; single Done.
- LW Addr=0x102, lo=0x44332211, hi=0x88776655 → two reads, RdData=0x66554433. With ALLOW_MISALIGN=0 → no BusReq, Done with Err=1.
- DMCtrl=110 load → Err=1, RdData=0, no bus activity. BusGnt held low 5 cycles → BusReq and fields stable, Stall stays 1.
- rst_n low while in WAIT0 → BusReq, Stall, and Done are 0 at once; a later BusRValid is ignored; the next Req completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Core-side request/response and word-wide data-memory bus signals.
// The design drives through the slave modport; the core/bus side uses master.
interface dmem_access_ctrl_if;
  logic        Req;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic        Stall;
  logic        Done;
  logic [31:0] RdData;
  logic        Err;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusBe;
  logic [31:0] BusWData;
  logic        BusGnt;
  logic [31:0] BusRData;
  logic        BusRValid;

  modport slave (
    input  Req, DMWr, DMCtrl, Addr, WrData, BusGnt, BusRData, BusRValid,
    output Stall, Done, RdData, Err, BusReq, BusWe, BusAddr, BusBe, BusWData
  );

  modport master (
    output Req, DMWr, DMCtrl, Addr, WrData, BusGnt, BusRData, BusRValid,
    input  Stall, Done, RdData, Err, BusReq, BusWe, BusAddr, BusBe, BusWData
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences RV32I loads/stores onto a handshaked word bus, splitting misaligned
// accesses into two word transactions; min latency 3 cycles (store), 4 (load).
module dmem_access_ctrl #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave mem_if
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE0 = 3'd1;
  localparam logic [2:0] WAIT0  = 3'd2;
  localparam logic [2:0] ISSUE1 = 3'd3;
  localparam logic [2:0] WAIT1  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  function automatic logic [2:0] size_of(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] code);
    return ({2'b00, off} + {1'b0, size_of(code)}) > 4'd4;
  endfunction

  // Codes 011/111 don't exist; 11x is unused; unsigned variants are load-only.
  function automatic logic illegal(input logic [2:0] ctrl, input logic we);
    return (ctrl[1:0] == 2'b11) || (ctrl[2] && (ctrl[1] || we));
  endfunction

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [23:0] hi_q, hi_d;
  logic        err_q, err_d;

  logic split;
  assign split = crosses(addr_q[1:0], ctrl_q[1:0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (mem_if.Req) begin
        addr_d  = mem_if.Addr;
        we_d    = mem_if.DMWr;
        ctrl_d  = mem_if.DMCtrl;
        wdata_d = mem_if.WrData;
        lo_d    = '0;
        hi_d    = '0;
        err_d   = illegal(mem_if.DMCtrl, mem_if.DMWr) ||
                  (!ALLOW_MISALIGN && crosses(mem_if.Addr[1:0], mem_if.DMCtrl[1:0]));
        state_d = err_d ? DONE : ISSUE0;
      end
      ISSUE0: if (mem_if.BusGnt) begin
        if (we_q) state_d = split ? ISSUE1 : DONE;
        else      state_d = WAIT0;
      end
      WAIT0: if (mem_if.BusRValid) begin
        lo_d    = mem_if.BusRData;
        state_d = split ? ISSUE1 : DONE;
      end
      ISSUE1: if (mem_if.BusGnt) state_d = we_q ? DONE : WAIT1;
      // Top byte of the high word never reaches the result, even at offset 3.
      WAIT1: if (mem_if.BusRValid) begin
        hi_d    = mem_if.BusRData[23:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Byte lanes and data across the two-word window the access may touch.
  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic        issuing, hi_phase;

  assign size_mask = (ctrl_q[1:0] == 2'b00) ? 4'b0001 :
                     (ctrl_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  assign be_wide   = {4'b0000, size_mask} << addr_q[1:0];
  assign wd_wide   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  assign issuing   = (state_q == ISSUE0) || (state_q == ISSUE1);
  assign hi_phase  = (state_q == ISSUE1);

  assign mem_if.BusReq   = issuing;
  assign mem_if.BusWe    = issuing && we_q;
  assign mem_if.BusAddr  = {addr_q[31:2], 2'b00} + (hi_phase ? 32'd4 : 32'd0);
  assign mem_if.BusBe    = (issuing && we_q) ? (hi_phase ? be_wide[7:4] : be_wide[3:0]) : 4'b0000;
  assign mem_if.BusWData = (issuing && we_q) ? (hi_phase ? wd_wide[63:32] : wd_wide[31:0]) : 32'h0;

  logic [31:0] aligned, extended;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    aligned = lo_q;
      2'd1:    aligned = {hi_q[7:0],  lo_q[31:8]};
      2'd2:    aligned = {hi_q[15:0], lo_q[31:16]};
      default: aligned = {hi_q[23:0], lo_q[31:24]};
    endcase
    case (ctrl_q)
      3'b000:  extended = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  extended = {{16{aligned[15]}}, aligned[15:0]};
      3'b010:  extended = aligned;
      3'b100:  extended = {24'h0, aligned[7:0]};
      3'b101:  extended = {16'h0, aligned[15:0]};
      default: extended = 32'h0;
    endcase
  end

  assign mem_if.Done   = (state_q == DONE);
  assign mem_if.Err    = (state_q == DONE) && err_q;
  assign mem_if.RdData = (state_q == DONE) ? extended : 32'h0;
  assign mem_if.Stall  = mem_if.Req && (state_q != DONE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected bus transactions and results are
// queued when a request is issued and checked as the DUT emits them.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if ifm();
  dmem_access_ctrl_if ifa();

  dmem_access_ctrl #(.ALLOW_MISALIGN(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .mem_if(ifm.slave));
  dmem_access_ctrl #(.ALLOW_MISALIGN(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .mem_if(ifa.slave));

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } res_t;

  txn_t        exp_txn_q[$];
  logic [31:0] rd_q[$];
  res_t        exp_res_q[$];

  int checks = 0;
  int errors = 0;
  int gnt_delay = 0;

  task automatic exp_txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    txn_t t;
    t.addr = a; t.we = we; t.be = be; t.wdata = wd;
    exp_txn_q.push_back(t);
  endtask

  task automatic exp_res(input logic [31:0] rd, input logic err);
    res_t r;
    r.rd = rd; r.err = err;
    exp_res_q.push_back(r);
  endtask

  task automatic bus_serve(input int n);
    for (int i = 0; i < n; i++) begin
      txn_t e;
      int   w;
      w = 0;
      while (ifm.BusReq !== 1'b1 && w < 40) begin
        @(negedge clk); #1;
        w++;
      end
      checks++;
      if (ifm.BusReq !== 1'b1) begin
        errors++;
        $display("FAIL bus_req_timeout txn %0d: BusReq=%b required 1", i, ifm.BusReq);
        return;
      end
      e = exp_txn_q.pop_front();
      checks++;
      if (ifm.BusAddr !== e.addr || ifm.BusWe !== e.we || ifm.BusBe !== e.be ||
          (e.we && ifm.BusWData !== e.wdata)) begin
        errors++;
        $display("FAIL bus_txn %0d: addr=%h we=%b be=%b wdata=%h required addr=%h we=%b be=%b wdata=%h",
                 i, ifm.BusAddr, ifm.BusWe, ifm.BusBe, ifm.BusWData, e.addr, e.we, e.be, e.wdata);
      end
      for (int d = 0; d < gnt_delay; d++) begin
        @(negedge clk); #1;
        checks++;
        if (ifm.BusReq !== 1'b1 || ifm.BusAddr !== e.addr || ifm.BusBe !== e.be || ifm.Stall !== 1'b1) begin
          errors++;
          $display("FAIL gnt_hold cycle %0d: req=%b addr=%h be=%b stall=%b required 1 %h %b 1",
                   d, ifm.BusReq, ifm.BusAddr, ifm.BusBe, ifm.Stall, e.addr, e.be);
        end
      end
      ifm.BusGnt = 1'b1;
      @(negedge clk); #1;
      ifm.BusGnt = 1'b0;
      if (!e.we) begin
        ifm.BusRData  = rd_q.pop_front();
        ifm.BusRValid = 1'b1;
        @(negedge clk); #1;
        ifm.BusRValid = 1'b0;
        ifm.BusRData  = 32'h0;
      end
    end
  endtask

  task automatic run_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdata, input int nexp, output int k_done);
    res_t r;
    bit   nobus;
    int   kd;
    kd = -1;
    nobus = 1'b1;
    fork
      begin
        @(negedge clk);
        ifm.Req = 1'b1; ifm.DMWr = we; ifm.DMCtrl = ctrl; ifm.Addr = addr; ifm.WrData = wdata;
        #1;
        checks++;
        if (ifm.Stall !== 1'b1) begin
          errors++;
          $display("FAIL stall_on_req addr=%h: Stall=%b required 1", addr, ifm.Stall);
        end
        for (int k = 1; k <= 60; k++) begin
          @(negedge clk); #1;
          if (nexp == 0 && ifm.BusReq !== 1'b0) nobus = 1'b0;
          if (ifm.Done === 1'b1) begin
            kd = k;
            break;
          end
        end
        checks++;
        if (kd < 0) begin
          errors++;
          $display("FAIL done_timeout addr=%h: Done=%b required 1", addr, ifm.Done);
        end else begin
          r = exp_res_q.pop_front();
          checks++;
          if (ifm.RdData !== r.rd || ifm.Err !== r.err || ifm.Stall !== 1'b0) begin
            errors++;
            $display("FAIL result addr=%h ctrl=%b: RdData=%h Err=%b Stall=%b required %h %b 0",
                     addr, ctrl, ifm.RdData, ifm.Err, ifm.Stall, r.rd, r.err);
          end
        end
        if (nexp == 0) begin
          checks++;
          if (!nobus) begin
            errors++;
            $display("FAIL no_bus addr=%h: BusReq seen 1 required 0", addr);
          end
        end
        ifm.Req = 1'b0;
      end
      bus_serve(nexp);
    join
    k_done = kd;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ifm.Stall !== 1'b0 || ifm.Done !== 1'b0 || ifm.Err !== 1'b0 || ifm.BusReq !== 1'b0 ||
        ifm.BusWe !== 1'b0 || ifm.BusBe !== 4'b0000 || ifm.RdData !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: stall=%b done=%b err=%b req=%b we=%b be=%b rd=%h required all 0",
               ifm.Stall, ifm.Done, ifm.Err, ifm.BusReq, ifm.BusWe, ifm.BusBe, ifm.RdData);
    end
    checks++;
    if (ifa.Done !== 1'b0 || ifa.BusReq !== 1'b0 || ifa.RdData !== 32'h0) begin
      errors++;
      $display("FAIL reset_state_nomis: done=%b req=%b rd=%h required 0 0 0", ifa.Done, ifa.BusReq, ifa.RdData);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_aligned();
    int k;
    exp_txn(32'h100, 1'b1, 4'b1111, 32'hDEADBEEF);
    exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, k);
    checks++;
    if (k !== 2) begin errors++; $display("FAIL sw_latency: done cycle %0d required 3", k + 1); end
    exp_txn(32'h100, 1'b1, 4'b0010, 32'h3456AB00);
    exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b000, 32'h101, 32'h123456AB, 1, k);
  endtask

  task automatic test_load_extend();
    int k;
    exp_txn(32'h200, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'hCAFEF00D); exp_res(32'hCAFEF00D, 1'b0);
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 1, k);
    checks++;
    if (k !== 3) begin errors++; $display("FAIL lw_latency: done cycle %0d required 4", k + 1); end
    exp_txn(32'h200, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80112233); exp_res(32'hFFFFFF80, 1'b0);
    run_access(1'b0, 3'b000, 32'h203, 32'h0, 1, k);
    exp_txn(32'h200, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80112233); exp_res(32'h00000080, 1'b0);
    run_access(1'b0, 3'b100, 32'h203, 32'h0, 1, k);
    exp_txn(32'h200, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80112233); exp_res(32'hFFFF8011, 1'b0);
    run_access(1'b0, 3'b001, 32'h202, 32'h0, 1, k);
    exp_txn(32'h200, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80112233); exp_res(32'h00008011, 1'b0);
    run_access(1'b0, 3'b101, 32'h202, 32'h0, 1, k);
  endtask

  task automatic test_store_split();
    int k;
    exp_txn(32'h100, 1'b1, 4'b1000, 32'hB2000000);
    exp_txn(32'h104, 1'b1, 4'b0001, 32'h000000A1);
    exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b001, 32'h103, 32'h0000A1B2, 2, k);
    checks++;
    if (k !== 3) begin errors++; $display("FAIL sh_split_latency: done cycle %0d required 4", k + 1); end
    exp_txn(32'hFFFFFFFC, 1'b1, 4'b1100, 32'h33440000);
    exp_txn(32'h00000000, 1'b1, 4'b0011, 32'h00001122);
    exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 2, k);
  endtask

  task automatic test_load_split();
    int k;
    exp_txn(32'h100, 1'b0, 4'b0000, 32'h0); exp_txn(32'h104, 1'b0, 4'b0000, 32'h0);
    rd_q.push_back(32'h44332211); rd_q.push_back(32'h88776655);
    exp_res(32'h66554433, 1'b0);
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 2, k);
    exp_txn(32'h1FC, 1'b0, 4'b0000, 32'h0); exp_txn(32'h200, 1'b0, 4'b0000, 32'h0);
    rd_q.push_back(32'hAABBCCDD); rd_q.push_back(32'h112233F4);
    exp_res(32'hFFFFF4AA, 1'b0);
    run_access(1'b0, 3'b001, 32'h1FF, 32'h0, 2, k);
  endtask

  task automatic test_illegal();
    int k;
    exp_res(32'h0, 1'b1);
    run_access(1'b0, 3'b110, 32'h300, 32'h0, 0, k);
    checks++;
    if (k !== 1) begin errors++; $display("FAIL illegal_latency: done cycle %0d required 2", k + 1); end
    exp_res(32'h0, 1'b1);
    run_access(1'b1, 3'b100, 32'h300, 32'hFFFFFFFF, 0, k);
    exp_res(32'h0, 1'b1);
    run_access(1'b0, 3'b011, 32'h304, 32'h0, 0, k);
  endtask

  task automatic test_gnt_stall();
    int k;
    gnt_delay = 5;
    exp_txn(32'h400, 1'b1, 4'b1111, 32'h12345678);
    exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b010, 32'h400, 32'h12345678, 1, k);
    gnt_delay = 0;
    checks++;
    if (k !== 7) begin errors++; $display("FAIL gnt_delay_latency: done cycle %0d required 8", k + 1); end
  endtask

  task automatic test_back_to_back();
    int k;
    exp_txn(32'h500, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h0BADF00D); exp_res(32'h0BADF00D, 1'b0);
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 1, k);
    exp_txn(32'h504, 1'b1, 4'b1100, 32'h55660000); exp_res(32'h0, 1'b0);
    run_access(1'b1, 3'b001, 32'h506, 32'h00005566, 1, k);
    checks++;
    if (k !== 2) begin errors++; $display("FAIL b2b_latency: done cycle %0d required 3", k + 1); end
    exp_txn(32'h504, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'hF1E2D3C4); exp_res(32'h000000E2, 1'b0);
    run_access(1'b0, 3'b100, 32'h506, 32'h0, 1, k);
  endtask

  task automatic test_reset_mid();
    int k;
    bit quiet;
    @(negedge clk);
    ifm.Req = 1'b1; ifm.DMWr = 1'b0; ifm.DMCtrl = 3'b010; ifm.Addr = 32'h300; ifm.WrData = 32'h0;
    @(negedge clk); #1;
    checks++;
    if (ifm.BusReq !== 1'b1) begin errors++; $display("FAIL mid_issue: BusReq=%b required 1", ifm.BusReq); end
    ifm.BusGnt = 1'b1;
    @(negedge clk); #1;
    ifm.BusGnt = 1'b0;
    rst_n = 1'b0;
    ifm.Req = 1'b0;
    #1;
    checks++;
    if (ifm.BusReq !== 1'b0 || ifm.Stall !== 1'b0 || ifm.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b stall=%b done=%b required 0 0 0", ifm.BusReq, ifm.Stall, ifm.Done);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    ifm.BusRData = 32'hBAD0BAD0;
    ifm.BusRValid = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      ifm.BusRValid = 1'b0;
      if (ifm.Done !== 1'b0 || ifm.BusReq !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL stale_rvalid: Done/BusReq went 1 required 0"); end
    exp_txn(32'h300, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h0F0F0F0F); exp_res(32'h0F0F0F0F, 1'b0);
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 1, k);
  endtask

  task automatic test_no_misalign();
    logic [2:0]  ctl_t[2];
    logic        we_t[2];
    logic [31:0] addr_t[2];
    ctl_t[0] = 3'b010; we_t[0] = 1'b0; addr_t[0] = 32'h102;
    ctl_t[1] = 3'b001; we_t[1] = 1'b1; addr_t[1] = 32'h103;
    for (int j = 0; j < 2; j++) begin
      res_t r;
      int   kd;
      bit   nobus;
      exp_res(32'h0, 1'b1);
      kd = -1; nobus = 1'b1;
      @(negedge clk);
      ifa.Req = 1'b1; ifa.DMWr = we_t[j]; ifa.DMCtrl = ctl_t[j]; ifa.Addr = addr_t[j]; ifa.WrData = 32'hA1B2;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk); #1;
        if (ifa.BusReq !== 1'b0) nobus = 1'b0;
        if (ifa.Done === 1'b1) begin kd = k; break; end
      end
      r = exp_res_q.pop_front();
      checks++;
      if (kd != 1 || ifa.Err !== r.err || ifa.RdData !== r.rd || !nobus) begin
        errors++;
        $display("FAIL nomis_%0d: done_k=%0d err=%b rd=%h nobus=%b required 1 %b %h 1",
                 j, kd, ifa.Err, ifa.RdData, nobus, r.err, r.rd);
      end
      ifa.Req = 1'b0;
    end
  endtask

  initial begin
    ifm.Req = 1'b0; ifm.DMWr = 1'b0; ifm.DMCtrl = 3'b000; ifm.Addr = 32'h0; ifm.WrData = 32'h0;
    ifm.BusGnt = 1'b0; ifm.BusRData = 32'h0; ifm.BusRValid = 1'b0;
    ifa.Req = 1'b0; ifa.DMWr = 1'b0; ifa.DMCtrl = 3'b000; ifa.Addr = 32'h0; ifa.WrData = 32'h0;
    ifa.BusGnt = 1'b0; ifa.BusRData = 32'h0; ifa.BusRValid = 1'b0;
    test_reset();
    test_store_aligned();
    test_load_extend();
    test_store_split();
    test_load_split();
    test_illegal();
    test_gnt_stall();
    test_back_to_back();
    test_reset_mid();
    test_no_misalign();
    checks++;
    if (exp_txn_q.size() != 0 || rd_q.size() != 0 || exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: txn=%0d rd=%0d res=%0d left required 0 0 0",
               exp_txn_q.size(), rd_q.size(), exp_res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
